// File: rtl/htrunc_seq.sv
// Iterative high-bit truncation: clears the k low-order bits of a 32-bit word
// by k single-bit right shifts followed by k single-bit left shifts.
module htrunc_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] In1,
  input  logic [4:0]  In2,
  input  logic        Start,
  output logic [31:0] Out,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  state_dbg
);

  // Handshake: Start is sampled on a rising edge only while Busy is low
  // (IDLE or DONE); a sampled Start captures In1/In2 on that edge. Done is
  // high for the one cycle in which a freshly completed Out is valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHR  = 2'd1,
    S_SHL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] work;
  logic [4:0]  cnt;
  logic [4:0]  k_lat;
  logic        accept;

  assign accept = Start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_nxt = (In2 == 5'd0) ? S_DONE : S_SHR;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SHR: if (cnt == 5'd1) state_nxt = S_SHL;
      S_SHL: if (cnt == 5'd1) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter reaching 1 marks the edge that applies the last shift of a phase,
  // so it never has to pass through zero (k = 31 cannot wrap).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= 32'h0;
      cnt   <= 5'd0;
      k_lat <= 5'd0;
      Out   <= 32'h0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            work  <= In1;
            cnt   <= In2;
            k_lat <= In2;
            if (In2 == 5'd0) Out <= In1;
          end
        end
        S_SHR: begin
          work <= {1'b0, work[31:1]};
          cnt  <= (cnt == 5'd1) ? k_lat : cnt - 5'd1;
        end
        S_SHL: begin
          work <= {work[30:0], 1'b0};
          if (cnt == 5'd1) begin
            Out <= {work[30:0], 1'b0};
            cnt <= 5'd0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Busy      = (state == S_SHR) || (state == S_SHL);
    Done      = (state == S_DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_htrunc_seq.sv
// Self-checking bench for htrunc_seq: directed vectors, random operations
// against a mask-based reference, busy-ignore, back-to-back and mid-op reset.
module tb_htrunc_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in1 = 32'h0;
  logic [4:0]  in2 = 5'd0;
  logic        start = 1'b0;
  logic [31:0] out_w;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  htrunc_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .In1(in1),
    .In2(in2),
    .Start(start),
    .Out(out_w),
    .Busy(busy),
    .Done(done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] trunc_model(input logic [31:0] a, input int k);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return a & (ones << k);
  endfunction

  // Launch one operation, scramble operands after acceptance, wait for Done.
  task automatic run_op(input logic [31:0] a, input logic [4:0] k,
                        output int lat, output int busy_n, output logic [31:0] res,
                        output logic seen, output logic stable, output logic done_after);
    logic [31:0] out_before;
    @(negedge clk);
    in1 = a; in2 = k; start = 1'b1;
    out_before = out_w;
    @(negedge clk);
    start = 1'b0; in1 = $urandom; in2 = 5'($urandom);
    lat = 0; busy_n = 0; stable = 1'b1;
    while (!done && lat < 80) begin
      if (busy) busy_n++;
      if (out_w !== out_before) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    seen = done;
    res = out_w;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    checks++;
    if (out_w !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state out=%h busy=%b done=%b required out=0 busy=0 done=0", out_w, busy, done);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va[4] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0001, 32'hDEAD_BEEF};
    int          vk[4] = '{4, 0, 31, 16};
    logic [31:0] ve[4] = '{32'hFFFF_FFF0, 32'h1234_5678, 32'h8000_0000, 32'hDEAD_0000};
    int lat, bn;
    logic [31:0] res;
    logic seen, stable, da;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], 5'(vk[i]), lat, bn, res, seen, stable, da);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL vec%0d_timeout no Done within %0d cycles", i, lat);
      end
      checks++;
      if (res !== ve[i]) begin
        errors++;
        $display("FAIL vec%0d_out got %h required %h", i, res, ve[i]);
      end
      checks++;
      if (lat != 2 * vk[i] || bn != 2 * vk[i]) begin
        errors++;
        $display("FAIL vec%0d_latency lat=%0d busy=%0d required %0d", i, lat, bn, 2 * vk[i]);
      end
      checks++;
      if (!stable || da !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_pulse stable=%b done_next=%b required stable=1 done_next=0", i, stable, da);
      end
    end
  endtask

  task automatic test_random();
    int lat, bn, k;
    logic [31:0] a, res;
    logic seen, stable, da;
    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      k = (i == 0) ? 31 : (i == 1) ? 0 : (i == 2) ? 1 : $urandom_range(0, 31);
      run_op(a, 5'(k), lat, bn, res, seen, stable, da);
      checks++;
      if (!seen || res !== trunc_model(a, k) || lat != 2 * k || bn != 2 * k || !stable || da !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d a=%h k=%0d out=%h lat=%0d busy=%0d stable=%b done_next=%b required out=%h lat=%0d",
                 i, a, k, res, lat, bn, stable, da, trunc_model(a, k), 2 * k);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [31:0] a, res;
    int dones, first_lat;
    a = $urandom | 32'h0000_8001;
    dones = 0; first_lat = -1; res = 32'h0;
    @(negedge clk);
    in1 = a; in2 = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        dones++;
        if (first_lat < 0) first_lat = i;
        res = out_w;
      end
      if (i == 3) begin start = 1'b1; in1 = ~a; in2 = 5'd3; end
      if (i == 4) begin start = 1'b0; in1 = $urandom; in2 = 5'($urandom); end
      @(negedge clk);
    end
    checks++;
    if (dones != 1 || first_lat != 16) begin
      errors++;
      $display("FAIL ignore_busy_count dones=%0d lat=%0d required dones=1 lat=16", dones, first_lat);
    end
    checks++;
    if (res !== trunc_model(a, 8)) begin
      errors++;
      $display("FAIL ignore_busy_out got %h required %h", res, trunc_model(a, 8));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, exp_v;
    int last, seen_n, gap;
    a = $urandom;
    exp_q.delete();
    exp_q.push_back(trunc_model(a, 2));
    @(negedge clk);
    in1 = a; in2 = 5'd2; start = 1'b1;
    @(negedge clk);
    last = -1; seen_n = 0;
    for (int i = 0; i < 40 && seen_n < 5; i++) begin
      if (done) begin
        gap = (last < 0) ? i + 1 : i - last;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        checks++;
        if (out_w !== exp_v || gap != 5) begin
          errors++;
          $display("FAIL b2b_done%0d out=%h gap=%0d required out=%h gap=5", seen_n, out_w, gap, exp_v);
        end
        last = i;
        seen_n++;
        if (seen_n < 5) begin
          a = $urandom;
          in1 = a;
          exp_q.push_back(trunc_model(a, 2));
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (seen_n != 5 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end dones=%0d done=%b busy=%b required dones=5 done=0 busy=0", seen_n, done, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bn, stray;
    logic [31:0] a, res;
    logic seen, stable, da;
    run_op(32'hFFFF_FFFF, 5'd1, lat, bn, res, seen, stable, da);
    @(negedge clk);
    in1 = $urandom; in2 = 5'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_w !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mid_pre busy=%b out=%h required busy=1 out=fffffffe", busy, out_w);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_w !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_async out=%h busy=%b done=%b required 0 0 0", out_w, busy, done);
    end
    stray = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) stray++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || out_w !== 32'h0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL mid_no_done stray=%0d required 0", stray);
    end
    a = $urandom;
    run_op(a, 5'd10, lat, bn, res, seen, stable, da);
    checks++;
    if (!seen || res !== trunc_model(a, 10) || lat != 20) begin
      errors++;
      $display("FAIL mid_recover out=%h lat=%0d required out=%h lat=20", res, lat, trunc_model(a, 10));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_vectors();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
